// File: rtl/sys_clk_pkg.sv
// Shared types and width helpers for the clock-enable generator.
package sys_clk_pkg;

  typedef enum logic [1:0] {SETTLE, RUN, REALIGN} state_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int settle_width(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/sys_clk_en_chan.sv
// One enable channel: holds its active divide ratio and a phase-loaded down-counter
// whose zero state produces the registered enable pulse.
module sys_clk_en_chan #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] n_in,
  input  logic [CNT_W-1:0] p_in,
  output logic             en
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] cnt;

  // en is computed one edge ahead so that it equals (cnt == 0) in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_act <= CNT_W'(DEF_DIV);
      cnt   <= '0;
      en    <= 1'b0;
    end else if (load) begin
      n_act <= n_in;
      cnt   <= p_in;
      en    <= (p_in == '0);
    end else if (run) begin
      if (cnt == '0) begin
        cnt <= n_act - ONE;
        en  <= (n_act == ONE);
      end else begin
        cnt <= cnt - ONE;
        en  <= (cnt == ONE);
      end
    end else begin
      en <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_clk_en_gen.sv
// Multi-channel clock-enable generator: settle/run/realign control, config
// validation and shadow registers, plus one enable channel per output bit.
module sys_clk_en_gen
  import sys_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  parameter int DEF_PHASE   = 0,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_apply,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_en,
  output logic              locked
);

  localparam int SW = settle_width(LOCK_CYCLES);

  state_t           state;
  state_t           next_state;
  logic [SW-1:0]    settle_cnt;
  logic             settle_done;
  logic             ch_ok;
  logic             wr_legal;
  logic             wr_fire;
  logic             commit;
  logic             chan_run;
  logic [CNT_W-1:0] shadow_div   [NUM_CH];
  logic [CNT_W-1:0] shadow_phase [NUM_CH];

  assign settle_done = (state != RUN) && (settle_cnt == SW'(LOCK_CYCLES - 1));
  assign ch_ok       = (int'(cfg_ch) < NUM_CH);
  assign wr_legal    = ch_ok && (cfg_div != '0) && (cfg_phase < cfg_div);
  assign wr_fire     = cfg_valid && cfg_ready;
  assign cfg_ready   = (state == RUN);
  assign locked      = (state == RUN);
  assign commit      = settle_done;
  assign chan_run    = (state == RUN) && !cfg_apply;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      cfg_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_div[i]   <= CNT_W'(DEF_DIV);
        shadow_phase[i] <= CNT_W'(DEF_PHASE);
      end
    end else begin
      state      <= next_state;
      settle_cnt <= (state == RUN || settle_done) ? '0 : settle_cnt + SW'(1);
      cfg_err    <= wr_fire && !wr_legal;
      if (wr_fire && wr_legal) begin
        shadow_div[cfg_ch]   <= cfg_div;
        shadow_phase[cfg_ch] <= cfg_phase;
      end
    end
  end

  // A write in the apply cycle lands in the shadow regs long before the commit.
  always_comb begin
    next_state = state;
    case (state)
      SETTLE, REALIGN: if (settle_done) next_state = RUN;
      RUN:             if (cfg_apply) next_state = REALIGN;
      default:         next_state = SETTLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    sys_clk_en_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk (refclk),
      .rst (rst),
      .load(commit),
      .run (chan_run),
      .n_in(shadow_div[i]),
      .p_in(shadow_phase[i]),
      .en  (clk_en[i])
    );
  end

endmodule

// File: tb/tb_sys_clk_en_gen.sv
// Directed bench for sys_clk_en_gen: each driven cycle pushes the predicted outputs
// of that cycle, and a negedge checker pops and compares them.
module tb_sys_clk_en_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int LOCK   = 16;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [0:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_apply;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_en;
  logic              locked;

  typedef struct {
    logic [1:0] en;
    logic       lk;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   t0      = 1000000;
  int   act_n[2] = '{2, 2};
  int   act_p[2] = '{0, 0};
  int   sh_n[2]  = '{2, 2};
  int   sh_p[2]  = '{0, 0};
  bit   exp_err = 1'b0;

  sys_clk_en_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .LOCK_CYCLES(LOCK),
    .DEF_DIV    (2),
    .DEF_PHASE  (0)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_apply(cfg_apply),
    .cfg_err  (cfg_err),
    .clk_en   (clk_en),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  // Expected outputs from the enable formula: high at T0 + P + k*N while locked.
  function automatic exp_t predict();
    exp_t e;
    int   d;
    e.lk  = (cyc >= t0);
    e.rdy = e.lk;
    e.err = exp_err;
    e.en  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      d = cyc - t0 - act_p[i];
      if (e.lk && d >= 0 && (d % act_n[i]) == 0) e.en[i] = 1'b1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input bit r, input bit vld, input int ch, input int div,
                               input int ph, input bit app);
    bit lk;
    bit err_n;
    @(posedge refclk);
    #1;
    cyc++;
    sb.push_back(predict());
    lk        = (cyc >= t0);
    rst       = r;
    cfg_valid = vld;
    cfg_ch    = ch[0:0];
    cfg_div   = div[15:0];
    cfg_phase = ph[15:0];
    cfg_apply = app;
    err_n     = 1'b0;
    if (r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        act_n[i] = 2; act_p[i] = 0; sh_n[i] = 2; sh_p[i] = 0;
      end
      t0 = cyc + 1 + LOCK;
    end else if (lk) begin
      if (vld) begin
        if (div != 0 && ph < div) begin
          sh_n[ch] = div;
          sh_p[ch] = ph;
        end else begin
          err_n = 1'b1;
        end
      end
      if (app) begin
        act_n = sh_n;
        act_p = sh_p;
        t0    = cyc + 1 + LOCK;
      end
    end
    exp_err = err_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge refclk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("clk_en", clk_en, e.en);
      checkOutput("locked", {1'b0, locked}, {1'b0, e.lk});
      checkOutput("cfg_ready", {1'b0, cfg_ready}, {1'b0, e.rdy});
      checkOutput("cfg_err", {1'b0, cfg_err}, {1'b0, e.err});
    end
  end

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    cfg_apply = 1'b0;
    $display("[TB] start");

    // Reset release and default N=2 enables.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(22);

    // Illegal writes (P>=N, then N=0) pulse cfg_err and leave defaults in place.
    applyStimulus(0, 1, 0, 4, 4, 0);
    idle(1);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(24);

    // Both channels N=5, channel 1 phase 2.
    applyStimulus(0, 1, 0, 5, 0, 0);
    applyStimulus(0, 1, 1, 5, 2, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(28);

    // Channel 1 N=1; during realign an apply and two writes must be ignored.
    applyStimulus(0, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 3, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    idle(24);

    // Reset during realign cycle 5 aborts it and restores defaults.
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(5);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(22);

    // Write and apply in the same cycle: channel 0 N=3 P=1.
    applyStimulus(0, 1, 0, 3, 1, 1);
    idle(24);

    @(negedge refclk);
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
